icc_flag_unit: RTL and testbench

Producer side of the SPARC integer condition codes: computes N, Z, V and C from ALU operands and result for cc-setting instructions, commits them through a one-entry pending stage, and drives the registered N_flag/Z_flag/V_flag/C_flag consumed by the branch condition checker. While an update is in flight, icc_busy tells the branch logic that the flags are stale.

---
 rtl/icc_pkg.sv | 22 ++
 rtl/icc_flag_unit_if.sv | 41 ++++
 rtl/icc_flag_calc.sv | 41 ++++
 rtl/icc_flag_unit.sv | 79 +++++++
 tb/tb_icc_flag_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/icc_pkg.sv
// icc_pkg: shared constants and types for the SPARC icc producer.
// Optional explicit icc write is enabled by ICC_WRPSR_EN.
package icc_pkg;

  localparam logic [1:0] ICC_LOGIC = 2'b00;
  localparam logic [1:0] ICC_ADD   = 2'b01;
  localparam logic [1:0] ICC_SUB   = 2'b10;
  localparam logic [1:0] ICC_NONE  = 2'b11;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef struct packed {
    logic        a31;
    logic        b31;
    logic [31:0] res;
    logic [1:0]  cls;
  } icc_pend_t;

endpackage

// File: rtl/icc_flag_unit_if.sv
// icc_flag_unit_if: ALU-side inputs and registered icc outputs.
// wr_en/wr_data exist only when ICC_WRPSR_EN is defined.
interface icc_flag_unit_if;

  logic        set_cc;
  logic [1:0]  op_class;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result;
  logic        stall;
`ifdef ICC_WRPSR_EN
  logic        wr_en;
  logic [3:0]  wr_data;
`endif
  logic        N_flag;
  logic        Z_flag;
  logic        V_flag;
  logic        C_flag;
  logic        icc_busy;

  modport master (
`ifdef ICC_WRPSR_EN
    output wr_en, wr_data,
`endif
    output set_cc, op_class, a_in, b_in,
    output result, stall,
    input  N_flag, Z_flag, V_flag, C_flag,
    input  icc_busy
  );

  modport slave (
`ifdef ICC_WRPSR_EN
    input  wr_en, wr_data,
`endif
    input  set_cc, op_class, a_in, b_in,
    input  result, stall,
    output N_flag, Z_flag, V_flag, C_flag,
    output icc_busy
  );

endinterface

// File: rtl/icc_flag_calc.sv
// icc_flag_calc: combinational {N,Z,V,C} from sign bits,
// result and op class.
module icc_flag_calc
  import icc_pkg::*;
(
  input  logic        a31_i,
  input  logic        b31_i,
  input  logic [31:0] res_i,
  input  logic [1:0]  cls_i,
  output logic [3:0]  flags_o
);

  logic r31;
  assign r31 = res_i[31];

  always_comb begin
    flags_o        = '0;
    flags_o[ICC_N] = r31;
    flags_o[ICC_Z] = ~|res_i;
    unique case (cls_i)
      ICC_ADD: begin
        flags_o[ICC_V] = (a31_i & b31_i & ~r31)
                       | (~a31_i & ~b31_i & r31);
        flags_o[ICC_C] = (a31_i & b31_i)
                       | ((a31_i | b31_i) & ~r31);
      end
      ICC_SUB: begin
        flags_o[ICC_V] = (a31_i & ~b31_i & ~r31)
                       | (~a31_i & b31_i & r31);
        // C is the borrow out of a - b
        flags_o[ICC_C] = (~a31_i & b31_i)
                       | ((~a31_i | b31_i) & r31);
      end
      default: begin
        flags_o[ICC_V] = 1'b0;
        flags_o[ICC_C] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/icc_flag_unit.sv
// icc_flag_unit: one-entry pending stage plus registered icc.
// ICC_WRPSR_EN adds an explicit write that overrides a commit.
module icc_flag_unit
  import icc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  icc_flag_unit_if.slave  bus
);

  icc_pend_t  pend_q, pend_d;
  logic       pv_q, pv_d;
  logic [3:0] icc_q, icc_d;
  logic [3:0] calc_flags;
  logic       capture, commit;
  logic       wr_hit;
  logic [3:0] wr_val;

  // Only the sign bits of the operands feed the flag rules
  logic unused_ops;
  assign unused_ops = ^{bus.a_in[30:0], bus.b_in[30:0]};

`ifdef ICC_WRPSR_EN
  assign wr_hit = bus.wr_en & ~bus.stall;
  assign wr_val = bus.wr_data;
`else
  assign wr_hit = 1'b0;
  assign wr_val = 4'b0000;
`endif

  assign capture = bus.set_cc & ~bus.stall
                 & (bus.op_class != ICC_NONE);
  assign commit  = pv_q & ~bus.stall;

  icc_flag_calc u_calc (
    .a31_i   (pend_q.a31),
    .b31_i   (pend_q.b31),
    .res_i   (pend_q.res),
    .cls_i   (pend_q.cls),
    .flags_o (calc_flags)
  );

  always_comb begin
    pend_d = pend_q;
    pv_d   = pv_q & bus.stall;
    icc_d  = icc_q;
    if (capture) begin
      pend_d.a31 = bus.a_in[31];
      pend_d.b31 = bus.b_in[31];
      pend_d.res = bus.result;
      pend_d.cls = bus.op_class;
      pv_d       = 1'b1;
    end
    unique case (1'b1)
      wr_hit:  icc_d = wr_val;
      commit:  icc_d = calc_flags;
      default: icc_d = icc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      pv_q   <= 1'b0;
      icc_q  <= 4'b0000;
    end else begin
      pend_q <= pend_d;
      pv_q   <= pv_d;
      icc_q  <= icc_d;
    end
  end

  assign bus.N_flag   = icc_q[ICC_N];
  assign bus.Z_flag   = icc_q[ICC_Z];
  assign bus.V_flag   = icc_q[ICC_V];
  assign bus.C_flag   = icc_q[ICC_C];
  assign bus.icc_busy = pv_q;

endmodule

// File: tb/tb_icc_flag_unit.sv
// tb_icc_flag_unit: directed + short random scoreboard bench.
// Exercises ICC_WRPSR_EN steps when that macro is defined.
module tb_icc_flag_unit;
  import icc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] q[$];

  icc_flag_unit_if bus();

  icc_flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {bus.N_flag, bus.Z_flag, bus.V_flag, bus.C_flag};
  endfunction

  // Reference model built from plain arithmetic
  function automatic logic [3:0] model(
    input logic [1:0] cls, input logic [31:0] a,
    input logic [31:0] b, output logic [31:0] r);
    logic [32:0] s;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    if (cls == ICC_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (cls == ICC_SUB) begin
      r = a - b;
      c = a < b;
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      r = a ^ b;
    end
    return {r[31], r == 32'd0, v, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      chk(tag, {28'd0, flags()}, {28'd0, q.pop_front()});
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
    bus.set_cc   = s;
    bus.op_class = c;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.result   = r;
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic [1:0]  rc;
    logic [3:0]  ex;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.stall = 1'b0;
`ifdef ICC_WRPSR_EN
    bus.wr_en   = 1'b0;
    bus.wr_data = 4'b0000;
`endif
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    tick();
    chk("reset_flags", {28'd0, flags()}, 0);
    chk("reset_busy", {31'd0, bus.icc_busy}, 0);
    reset = 1'b0;
    tick();

    // ADD overflow into the sign bit
    drive(1'b1, ICC_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    q.push_back(4'b1010);
    tick();
    chk("add_busy_hi", {31'd0, bus.icc_busy}, 1);
    chk("add_flags_old", {28'd0, flags()}, 0);
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    chk_pop("add_flags");
    chk("add_busy_lo", {31'd0, bus.icc_busy}, 0);

    // SUB borrow then LOGIC zero, back to back
    drive(1'b1, ICC_SUB, 32'h0, 32'h1, 32'hFFFFFFFF);
    q.push_back(4'b1001);
    tick();
    chk("sub_busy", {31'd0, bus.icc_busy}, 1);
    drive(1'b1, ICC_LOGIC, 32'h0, 32'h0, 32'h0);
    q.push_back(4'b0100);
    tick();
    chk_pop("sub_flags");
    chk("b2b_busy", {31'd0, bus.icc_busy}, 1);
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    chk_pop("logic_flags");
    chk("logic_busy", {31'd0, bus.icc_busy}, 0);

    // ADD with zero result held by stall
    drive(1'b1, ICC_ADD, 32'h80000000, 32'h80000000, 32'h0);
    q.push_back(4'b0111);
    tick();
    bus.stall = 1'b1;
    drive(1'b1, ICC_LOGIC, 32'h1, 32'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flags", {28'd0, flags()}, 32'h4);
      chk("stall_busy", {31'd0, bus.icc_busy}, 1);
    end
    bus.stall = 1'b0;
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    chk_pop("stall_release");
    chk("stall_rel_busy", {31'd0, bus.icc_busy}, 0);

    // op_class NONE is not captured
    drive(1'b1, ICC_NONE, 32'h0, 32'h0, 32'h0);
    tick();
    chk("none_busy", {31'd0, bus.icc_busy}, 0);
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    chk("none_flags", {28'd0, flags()}, 32'h7);

    // Random back-to-back stream against the model
    for (int i = 0; i < 9; i++) begin
      rc = 2'(i % 3);
      ra = $urandom;
      rb = (i == 4) ? ra : $urandom;
      ex = model(rc, ra, rb, rr);
      drive(1'b1, rc, ra, rb, rr);
      q.push_back(ex);
      tick();
      if (i > 0) chk_pop("rand_flags");
    end
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    tick();
    chk_pop("rand_last");

    // Asynchronous reset with an update pending
    drive(1'b1, ICC_SUB, 32'h1, 32'h2, 32'hFFFFFFFF);
    tick();
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    chk("pre_rst_busy", {31'd0, bus.icc_busy}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, bus.icc_busy}, 0);
    chk("rst_mid_flags", {28'd0, flags()}, 0);
    q.delete();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_discard", {28'd0, flags()}, 0);
    chk("rst_idle_busy", {31'd0, bus.icc_busy}, 0);

`ifdef ICC_WRPSR_EN
    // Explicit write beats a due commit
    drive(1'b1, ICC_LOGIC, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'b1010;
    tick();
    bus.wr_en = 1'b0;
    chk("wr_flags", {28'd0, flags()}, 32'hA);
    chk("wr_busy", {31'd0, bus.icc_busy}, 0);
    // Write plus simultaneous capture
    drive(1'b1, ICC_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'b0001;
    tick();
    bus.wr_en = 1'b0;
    drive(1'b0, ICC_LOGIC, 0, 0, 0);
    chk("wr_cap_flags", {28'd0, flags()}, 32'h1);
    chk("wr_cap_busy", {31'd0, bus.icc_busy}, 1);
    tick();
    chk("wr_cap_commit", {28'd0, flags()}, 32'hA);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
